// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop/lap/clear FSM over a BCD mm:ss.cc counter clocked by 100 Hz tick edges.
// Events act on the clock edge that sees them; display is combinational from registers; no backpressure.
module stopwatch_ctrl #(
  parameter int MIN_MAX = 59
) (
  input  logic       clk_50mhz,
  input  logic       rst,
  input  logic       clk_100hz,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic       div_rst,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_cs,
  output logic [1:0] state,
  output logic       wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [7:0] MIN_TOP = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  state_t     cur_state, nxt_state;
  logic       armed;
  logic       start_q, lap_q, clear_q, tick_q;
  logic       start_ev, lap_ev, clear_ev, tick_ev;
  logic       count_en, clr_en, lap_entry, at_top;
  logic [7:0] live_min, live_sec, live_cs;
  logic [7:0] lap_min, lap_sec, lap_cs;
  logic [7:0] inc_min, inc_sec, inc_cs;

  // armed stays low for the first edge after reset so a level already high is absorbed, not seen as an edge
  assign start_ev = armed & btn_start & ~start_q;
  assign lap_ev   = armed & btn_lap   & ~lap_q;
  assign clear_ev = armed & btn_clear & ~clear_q;
  assign tick_ev  = armed & clk_100hz & ~tick_q;

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b0;
      start_q <= 1'b0;
      lap_q   <= 1'b0;
      clear_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      armed   <= 1'b1;
      start_q <= btn_start;
      lap_q   <= btn_lap;
      clear_q <= btn_clear;
      tick_q  <= clk_100hz;
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) cur_state <= IDLE;
    else      cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    div_rst   = 1'b0;
    case (cur_state)
      IDLE: begin
        div_rst = 1'b1;
        if (!clear_ev && start_ev) nxt_state = RUN;
      end
      RUN: begin
        if (start_ev)    nxt_state = PAUSE;
        else if (lap_ev) nxt_state = LAP;
      end
      LAP: begin
        if (start_ev)    nxt_state = PAUSE;
        else if (lap_ev) nxt_state = RUN;
      end
      PAUSE: begin
        div_rst = 1'b1;
        if (clear_ev)      nxt_state = IDLE;
        else if (start_ev) nxt_state = RUN;
      end
      default: nxt_state = IDLE;
    endcase
  end

  assign count_en  = tick_ev & ((cur_state == RUN) | (cur_state == LAP));
  assign clr_en    = clear_ev & ((cur_state == IDLE) | (cur_state == PAUSE));
  assign lap_entry = (cur_state == RUN) & (nxt_state == LAP);

  // BCD ripple: each digit carries only when every lower digit is at its terminal value
  always_comb begin
    inc_cs = live_cs;
    inc_sec = live_sec;
    inc_min = live_min;
    at_top = 1'b0;
    if (live_cs[3:0] != 4'd9) begin
      inc_cs[3:0] = live_cs[3:0] + 4'd1;
    end else if (live_cs[7:4] != 4'd9) begin
      inc_cs = {live_cs[7:4] + 4'd1, 4'd0};
    end else begin
      inc_cs = 8'h00;
      if (live_sec[3:0] != 4'd9) begin
        inc_sec[3:0] = live_sec[3:0] + 4'd1;
      end else if (live_sec[7:4] != 4'd5) begin
        inc_sec = {live_sec[7:4] + 4'd1, 4'd0};
      end else begin
        inc_sec = 8'h00;
        if (live_min == MIN_TOP) begin
          inc_min = 8'h00;
          at_top  = 1'b1;
        end else if (live_min[3:0] != 4'd9) begin
          inc_min[3:0] = live_min[3:0] + 4'd1;
        end else begin
          inc_min = {live_min[7:4] + 4'd1, 4'd0};
        end
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      live_min <= 8'h00;
      live_sec <= 8'h00;
      live_cs  <= 8'h00;
      lap_min  <= 8'h00;
      lap_sec  <= 8'h00;
      lap_cs   <= 8'h00;
      wrap     <= 1'b0;
    end else begin
      wrap <= count_en & at_top;
      if (clr_en) begin
        live_min <= 8'h00;
        live_sec <= 8'h00;
        live_cs  <= 8'h00;
        lap_min  <= 8'h00;
        lap_sec  <= 8'h00;
        lap_cs   <= 8'h00;
      end else begin
        if (count_en) begin
          live_min <= inc_min;
          live_sec <= inc_sec;
          live_cs  <= inc_cs;
        end
        // the latch captures the time including a tick counted on the same edge
        if (lap_entry) begin
          lap_min <= count_en ? inc_min : live_min;
          lap_sec <= count_en ? inc_sec : live_sec;
          lap_cs  <= count_en ? inc_cs  : live_cs;
        end
      end
    end
  end

  assign state    = cur_state;
  assign disp_min = (cur_state == LAP) ? lap_min : live_min;
  assign disp_sec = (cur_state == LAP) ? lap_sec : live_sec;
  assign disp_cs  = (cur_state == LAP) ? lap_cs  : live_cs;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: integer-centisecond reference model checked every cycle, plus directed literal checks.
module tb_stopwatch_ctrl;

  localparam int PERIOD = 60 * 6000;
  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_LAP = 2'b11;

  logic clk_50mhz = 1'b0;
  logic rst;
  logic clk_100hz, btn_start, btn_lap, btn_clear;
  logic div_rst, wrap, div_rst_b, wrap_b;
  logic [7:0] disp_min, disp_sec, disp_cs, disp_min_b, disp_sec_b, disp_cs_b;
  logic [1:0] state, state_b;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic chk_en = 1'b0;

  stopwatch_ctrl #(.MIN_MAX(59)) dut (
    .clk_50mhz(clk_50mhz), .rst(rst), .clk_100hz(clk_100hz),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .div_rst(div_rst), .disp_min(disp_min), .disp_sec(disp_sec), .disp_cs(disp_cs),
    .state(state), .wrap(wrap)
  );

  stopwatch_ctrl #(.MIN_MAX(1)) dut_b (
    .clk_50mhz(clk_50mhz), .rst(rst), .clk_100hz(clk_100hz),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .div_rst(div_rst_b), .disp_min(disp_min_b), .disp_sec(disp_sec_b), .disp_cs(disp_cs_b),
    .state(state_b), .wrap(wrap_b)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  logic [27:0] dut_vec, dutb_vec, exp_vec;
  assign dut_vec  = {state, div_rst, disp_min, disp_sec, disp_cs, wrap};
  assign dutb_vec = {state_b, div_rst_b, disp_min_b, disp_sec_b, disp_cs_b, wrap_b};

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h required %h (state,div_rst,min,sec,cs,wrap)", name, act, expv);
  endtask

  // Reference model: time as a plain count of centiseconds
  logic [1:0] m_st;
  int m_t, m_lap, m_inc, shown_t;
  logic m_wrap, m_armed, p_s, p_l, p_c, p_k;
  logic e_s, e_l, e_c, e_k, m_cnt;

  always_comb begin
    e_s = m_armed && btn_start && !p_s;
    e_l = m_armed && btn_lap && !p_l;
    e_c = m_armed && btn_clear && !p_c;
    e_k = m_armed && clk_100hz && !p_k;
    m_cnt = e_k && (m_st == ST_RUN || m_st == ST_LAP);
    m_inc = (m_t + 1) % PERIOD;
    shown_t = (m_st == ST_LAP) ? m_lap : m_t;
    exp_vec = {m_st, (m_st == ST_IDLE || m_st == ST_PAUSE),
               bcd(shown_t / 6000), bcd((shown_t / 100) % 60), bcd(shown_t % 100), m_wrap};
  end

  always @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      m_st <= ST_IDLE; m_t <= 0; m_lap <= 0; m_wrap <= 1'b0; m_armed <= 1'b0;
      p_s <= 1'b0; p_l <= 1'b0; p_c <= 1'b0; p_k <= 1'b0;
    end else begin
      m_armed <= 1'b1;
      p_s <= btn_start; p_l <= btn_lap; p_c <= btn_clear; p_k <= clk_100hz;
      m_wrap <= m_cnt && (m_t == PERIOD - 1);
      if (m_cnt) m_t <= m_inc;
      case (m_st)
        ST_IDLE:  if (e_c) begin m_t <= 0; m_lap <= 0; end
                  else if (e_s) m_st <= ST_RUN;
        ST_RUN:   if (e_s) m_st <= ST_PAUSE;
                  else if (e_l) begin m_st <= ST_LAP; m_lap <= m_cnt ? m_inc : m_t; end
        ST_LAP:   if (e_s) m_st <= ST_PAUSE;
                  else if (e_l) m_st <= ST_RUN;
        default:  if (e_c) begin m_st <= ST_IDLE; m_t <= 0; m_lap <= 0; end
                  else if (e_s) m_st <= ST_RUN;
      endcase
    end
  end

  always @(negedge clk_50mhz) begin
    if (chk_en) check("cycle_model", dut_vec, exp_vec);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      clk_100hz = 1'b1;
      @(negedge clk_50mhz);
      clk_100hz = 1'b0;
      @(negedge clk_50mhz);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_start = 1'b1;
    else if (which == 1) btn_lap = 1'b1;
    else btn_clear = 1'b1;
    @(negedge clk_50mhz);
    btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    @(negedge clk_50mhz);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clk_100hz = 1'b0; btn_start = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    @(negedge clk_50mhz);
    chk_en = 1'b1;
    @(negedge clk_50mhz);
    check("reset_state", dut_vec, {2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
    rst = 1'b1;
    repeat (2) @(negedge clk_50mhz);

    // start then 150 ticks
    press(0);
    tick(150);
    check("run_150_ticks", dut_vec, {2'b01, 1'b0, 8'h00, 8'h01, 8'h50, 1'b0});
    check("model_150_ticks", exp_vec, {2'b01, 1'b0, 8'h00, 8'h01, 8'h50, 1'b0});

    // lap at 00:05.20, count underneath, lap again
    tick(370);
    press(1);
    tick(30);
    check("lap_frozen", dut_vec, {2'b11, 1'b0, 8'h00, 8'h05, 8'h20, 1'b0});
    btn_lap = 1'b1;
    @(negedge clk_50mhz);
    check("lap_exit_live", dut_vec, {2'b01, 1'b0, 8'h00, 8'h05, 8'h50, 1'b0});
    check("model_lap_exit", exp_vec, {2'b01, 1'b0, 8'h00, 8'h05, 8'h50, 1'b0});
    btn_lap = 1'b0;
    @(negedge clk_50mhz);

    // pause at 00:03.00, ticks ignored, clear
    press(0);
    press(2);
    press(0);
    tick(300);
    press(0);
    check("pause_hold", dut_vec, {2'b10, 1'b1, 8'h00, 8'h03, 8'h00, 1'b0});
    tick(20);
    check("pause_ticks_ignored", dut_vec, {2'b10, 1'b1, 8'h00, 8'h03, 8'h00, 1'b0});
    press(2);
    check("clear_to_idle", dut_vec, {2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});

    // clear ignored in RUN; start+clear together in PAUSE -> clear wins
    press(0);
    tick(10);
    press(2);
    check("clear_in_run", dut_vec, {2'b01, 1'b0, 8'h00, 8'h00, 8'h10, 1'b0});
    press(0);
    btn_start = 1'b1; btn_clear = 1'b1;
    @(negedge clk_50mhz);
    check("clear_beats_start", dut_vec, {2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
    btn_start = 1'b0; btn_clear = 1'b0;
    @(negedge clk_50mhz);

    // async reset mid-run with start held through release
    press(0);
    tick(50);
    btn_start = 1'b1;
    #3 rst = 1'b0;
    #1 check("async_reset_now", dut_vec, {2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
    repeat (3) @(negedge clk_50mhz);
    rst = 1'b1;
    repeat (3) @(negedge clk_50mhz);
    check("no_start_at_release", dut_vec, {2'b00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0});
    btn_start = 1'b0;
    @(negedge clk_50mhz);

    // minute carry on both instances; wrap on the MIN_MAX=1 instance
    press(0);
    tick(5999);
    check("at_00_59_99", dut_vec, {2'b01, 1'b0, 8'h00, 8'h59, 8'h99, 1'b0});
    check("b_at_00_59_99", dutb_vec, {2'b01, 1'b0, 8'h00, 8'h59, 8'h99, 1'b0});
    tick(1);
    check("min_carry", dut_vec, {2'b01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0});
    check("b_min_carry", dutb_vec, {2'b01, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0});
    tick(5999);
    check("b_at_top", dutb_vec, {2'b01, 1'b0, 8'h01, 8'h59, 8'h99, 1'b0});
    clk_100hz = 1'b1;
    @(negedge clk_50mhz);
    check("b_wrap_pulse", dutb_vec, {2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1});
    clk_100hz = 1'b0;
    @(negedge clk_50mhz);
    check("b_wrap_one_cycle", dutb_vec, {2'b01, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0});

    // randomized phase: at most one button level changes per cycle
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        #3 rst = 1'b0;
        @(negedge clk_50mhz);
        @(negedge clk_50mhz);
        rst = 1'b1;
      end else begin
        if (r < 60) btn_start = ~btn_start;
        else if (r < 110) btn_lap = ~btn_lap;
        else if (r < 130) btn_clear = ~btn_clear;
        if ($urandom_range(0, 2) == 0) clk_100hz = ~clk_100hz;
        @(negedge clk_50mhz);
      end
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
